// File: rtl/led_fan_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : led_fan_pkg
//  Purpose  : Shared defaults and scheduler state encoding for the LED fan
//             column scheduler.
//  Revision : 1.0 - initial release
// ============================================================================
package led_fan_pkg;

  localparam int DEF_NUM_COLS   = 128;
  localparam int DEF_COL_W      = $clog2(DEF_NUM_COLS);
  localparam int DEF_PERIOD_W   = 24;
  localparam int DEF_MIN_PERIOD = 4096;
  localparam int DEF_MAX_PERIOD = (2 ** DEF_PERIOD_W) - 1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_RUN     = 2'd2
  } sched_state_e;

endpackage
`default_nettype wire

// File: rtl/hall_sync_edge.sv
`default_nettype none
// ============================================================================
//  Module   : hall_sync_edge
//  Purpose  : Two-flop synchronizer for the asynchronous hall pin followed by
//             a rising-edge detector. A pin rise sampled at edge k produces
//             hall_rise that the consumer acts on at edge k+2.
//  Revision : 1.0 - initial release
// ============================================================================
module hall_sync_edge
  import led_fan_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic hall,
  output logic hall_rise
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic prev_q,  prev_d;

  // Shift the pin through the synchronizer and keep one delayed copy for edge detection
  always_comb begin
    sync1_d = hall;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
  end

  // Synchronizer and history flops
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
    end
  end

  // Rise is taken only from already-synchronized flops, never from the raw pin
  assign hall_rise = sync2_q & ~prev_q;

endmodule
`default_nettype wire

// File: rtl/column_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : column_scheduler
//  Purpose  : Measures the fan revolution period from the hall index sensor
//             and spreads NUM_COLS column strobes evenly across each
//             revolution, with a programmable column phase offset.
//  Revision : 1.0 - initial release
// ============================================================================
module column_scheduler
  import led_fan_pkg::*;
#(
  parameter int NUM_COLS   = DEF_NUM_COLS,
  parameter int PERIOD_W   = DEF_PERIOD_W,
  parameter int MIN_PERIOD = DEF_MIN_PERIOD,
  parameter int MAX_PERIOD = DEF_MAX_PERIOD
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        hall,
  input  logic                        en,
  input  logic [$clog2(NUM_COLS)-1:0] offset,
  output logic [$clog2(NUM_COLS)-1:0] col_addr,
  output logic                        col_strobe,
  output logic                        blank,
  output logic                        locked,
  output logic [PERIOD_W-1:0]         rev_period
);

  localparam int                  COL_W    = $clog2(NUM_COLS);
  localparam int                  INT_W    = PERIOD_W - COL_W;
  localparam logic [PERIOD_W-1:0] MIN_P    = PERIOD_W'(MIN_PERIOD);
  localparam logic [PERIOD_W-1:0] MAX_P    = PERIOD_W'(MAX_PERIOD);
  localparam logic [COL_W-1:0]    LAST_COL = COL_W'(NUM_COLS - 1);

  logic                hall_rise;
  logic                accept;
  logic                stall;

  sched_state_e        state_q,        state_d;
  logic [PERIOD_W-1:0] per_cnt_q,      per_cnt_d;
  logic [PERIOD_W-1:0] rev_period_q,   rev_period_d;
  logic [INT_W-1:0]    col_interval_q, col_interval_d;
  logic [INT_W-1:0]    col_tmr_q,      col_tmr_d;
  logic [COL_W-1:0]    col_cnt_q,      col_cnt_d;
  logic [COL_W-1:0]    off_q,          off_d;
  logic [COL_W-1:0]    col_addr_q,     col_addr_d;
  logic                col_strobe_q,   col_strobe_d;
  logic                locked_q,       locked_d;
  logic                blank_q,        blank_d;

  hall_sync_edge u_hall_sync_edge (
    .clk       (clk),
    .rst       (rst),
    .hall      (hall),
    .hall_rise (hall_rise)
  );

  // In IDLE any rise starts acquisition; otherwise rises too close to the
  // previous accepted edge are treated as sensor glitches.
  assign accept = hall_rise && ((state_q == ST_IDLE) || (per_cnt_q >= MIN_P));
  // A saturated period counter means the fan has stopped turning.
  assign stall  = !accept && (state_q != ST_IDLE) && (per_cnt_q == MAX_P);

  // Next-state, period measurement and column scheduling decisions
  always_comb begin
    state_d        = state_q;
    per_cnt_d      = (per_cnt_q == MAX_P) ? per_cnt_q : per_cnt_q + PERIOD_W'(1);
    rev_period_d   = rev_period_q;
    col_interval_d = col_interval_q;
    col_tmr_d      = col_tmr_q;
    col_cnt_d      = col_cnt_q;
    off_d          = off_q;
    col_strobe_d   = 1'b0;

    if (accept) begin
      // Restart at 1 so the value seen at the next accepted edge is the exact
      // cycle distance between the two edges.
      per_cnt_d = PERIOD_W'(1);
      if (state_q == ST_IDLE) begin
        state_d = ST_ACQUIRE;
      end else begin
        // Entry to RUN and every edge in RUN: measure, realign, restart columns
        state_d        = ST_RUN;
        rev_period_d   = per_cnt_q;
        col_interval_d = per_cnt_q[PERIOD_W-1:COL_W];
        col_tmr_d      = '0;
        col_cnt_d      = '0;
        off_d          = offset;
        col_strobe_d   = 1'b1;
      end
    end else if (stall) begin
      state_d = ST_IDLE;
    end else if (state_q == ST_RUN) begin
      // Column timer; once the last column is reached it keeps running but
      // no further columns are issued until the next edge realigns.
      if (col_tmr_q == col_interval_q - INT_W'(1)) begin
        col_tmr_d = '0;
        if (col_cnt_q != LAST_COL) begin
          col_cnt_d    = col_cnt_q + COL_W'(1);
          col_strobe_d = 1'b1;
        end
      end else begin
        col_tmr_d = col_tmr_q + INT_W'(1);
      end
    end

    if (state_d != ST_RUN) begin
      col_strobe_d = 1'b0;
    end

    col_addr_d = col_cnt_d + off_d;
    locked_d   = (state_d == ST_RUN);
    blank_d    = !((state_d == ST_RUN) && en);
  end

  // State, measurement and registered output flops
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      per_cnt_q      <= '0;
      rev_period_q   <= '0;
      col_interval_q <= '0;
      col_tmr_q      <= '0;
      col_cnt_q      <= '0;
      off_q          <= '0;
      col_addr_q     <= '0;
      col_strobe_q   <= 1'b0;
      locked_q       <= 1'b0;
      blank_q        <= 1'b1;
    end else begin
      state_q        <= state_d;
      per_cnt_q      <= per_cnt_d;
      rev_period_q   <= rev_period_d;
      col_interval_q <= col_interval_d;
      col_tmr_q      <= col_tmr_d;
      col_cnt_q      <= col_cnt_d;
      off_q          <= off_d;
      col_addr_q     <= col_addr_d;
      col_strobe_q   <= col_strobe_d;
      locked_q       <= locked_d;
      blank_q        <= blank_d;
    end
  end

  assign col_addr   = col_addr_q;
  assign col_strobe = col_strobe_q;
  assign locked     = locked_q;
  assign blank      = blank_q;
  assign rev_period = rev_period_q;

endmodule
`default_nettype wire

// File: tb/tb_column_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_column_scheduler
//  Purpose  : Self-checking bench for column_scheduler with an event-level
//             reference model (accepted-edge times and period arithmetic).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_column_scheduler;

  localparam int NC   = 8;
  localparam int MINP = 64;
  localparam int MAXP = 4096;

  logic        clk;
  logic        rst;
  logic        hall;
  logic        en;
  logic [2:0]  offset;
  logic [2:0]  col_addr;
  logic        col_strobe;
  logic        blank;
  logic        locked;
  logic [23:0] rev_period;

  int n_tests;
  int n_fail;

  // Reference model state: expressed as edge times and arithmetic on them
  int cyc;
  int m_state;      // 0 idle, 1 acquire, 2 run
  int m_last;       // cycle of last accepted edge
  int m_rev;
  int m_int;
  int m_off;
  int m_addr;
  bit m_strobe;
  bit m_locked;
  bit m_blank;
  bit h1, h2, h3;   // pin value sampled 1, 2 and 3 edges ago

  column_scheduler #(
    .NUM_COLS   (NC),
    .PERIOD_W   (24),
    .MIN_PERIOD (MINP),
    .MAX_PERIOD (MAXP)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .hall       (hall),
    .en         (en),
    .offset     (offset),
    .col_addr   (col_addr),
    .col_strobe (col_strobe),
    .blank      (blank),
    .locked     (locked),
    .rev_period (rev_period)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  // Drive one cycle of inputs, advance the model by one edge, sample at negedge
  task automatic cycle(input bit h, input bit e, input bit r, input int o);
    bit rise;
    int j;
    int n;
    hall   = h;
    en     = e;
    rst    = r;
    offset = 3'(o);
    @(posedge clk);
    cyc++;
    if (r) begin
      m_state = 0; m_rev = 0; m_addr = 0; m_off = 0; m_strobe = 0;
      h1 = 0; h2 = 0; h3 = 0;
    end else begin
      rise = h2 && !h3;
      h3 = h2; h2 = h1; h1 = h;
      if (rise && (m_state == 0 || cyc - m_last >= MINP)) begin
        if (m_state == 0) begin
          m_state = 1;
        end else begin
          m_state = 2;
          m_rev   = cyc - m_last;
          m_int   = m_rev / NC;
          m_off   = o;
        end
        m_last = cyc;
      end else if (m_state != 0 && cyc - m_last >= MAXP) begin
        m_state = 0;
      end
      if (m_state == 2) begin
        j        = cyc - m_last;
        n        = j / m_int;
        m_strobe = (j % m_int == 0) && (n < NC);
        if (n > NC - 1) n = NC - 1;
        m_addr   = (m_off + n) % NC;
      end else begin
        m_strobe = 0;
      end
    end
    m_locked = (m_state == 2);
    m_blank  = !(m_state == 2 && e);
    @(negedge clk);
  endtask

  task automatic test_reset();
    cycle(0, 0, 1, 0);
    cycle(0, 0, 1, 0);
    n_tests++;
    if (col_addr !== 3'd0 || col_strobe !== 1'b0 || locked !== 1'b0 || blank !== 1'b1 || rev_period !== 24'd0) begin
      n_fail++;
      $display("FAIL reset_values addr=%0d strobe=%b locked=%b blank=%b rev=%0d expected 0,0,0,1,0",
               col_addr, col_strobe, locked, blank, rev_period);
    end
    for (int i = 0; i < 20; i++) begin
      cycle(0, 1, 0, 0);
      n_tests++;
      if (locked !== 1'b0 || blank !== 1'b1 || col_strobe !== 1'b0) begin
        n_fail++;
        $display("FAIL idle_hold cyc=%0d locked=%b blank=%b strobe=%b expected 0,1,0", cyc, locked, blank, col_strobe);
      end
    end
  endtask

  task automatic test_steady();
    int addrs[$];
    int strobes;
    for (int r = 0; r < 5; r++) begin
      strobes = 0;
      addrs.delete();
      for (int t = 0; t < 800; t++) begin
        cycle(t < 5, 1'b1, 1'b0, 0);
        n_tests++;
        if (col_strobe !== m_strobe || col_addr !== 3'(m_addr) || locked !== m_locked || blank !== m_blank) begin
          n_fail++;
          $display("FAIL steady cyc=%0d strobe=%b exp %b addr=%0d exp %0d locked=%b exp %b blank=%b exp %b",
                   cyc, col_strobe, m_strobe, col_addr, m_addr, locked, m_locked, blank, m_blank);
        end
        if (col_strobe === 1'b1) begin
          strobes++;
          addrs.push_back(int'(col_addr));
        end
        if (r == 0 && t == 799) begin
          n_tests++;
          if (locked !== 1'b0) begin
            n_fail++;
            $display("FAIL steady_not_locked_after_first_rise locked=%b expected 0", locked);
          end
        end
        if (r == 1 && t == 3) begin
          n_tests++;
          if (locked !== 1'b1) begin
            n_fail++;
            $display("FAIL steady_locked_after_second_rise locked=%b expected 1", locked);
          end
        end
      end
    end
    n_tests++;
    if (rev_period !== 24'd800) begin
      n_fail++;
      $display("FAIL steady_rev_period got %0d expected 800", rev_period);
    end
    n_tests++;
    if (strobes != 8 || addrs.size() != 8) begin
      n_fail++;
      $display("FAIL steady_strobe_count got %0d expected 8", strobes);
    end else begin
      for (int i = 0; i < 8; i++) begin
        n_tests++;
        if (addrs[i] != i) begin
          n_fail++;
          $display("FAIL steady_addr_seq idx=%0d got %0d expected %0d", i, addrs[i], i);
        end
      end
    end
  endtask

  task automatic test_glitch();
    for (int r = 0; r < 3; r++) begin
      for (int t = 0; t < 800; t++) begin
        cycle((t < 5) || (t >= 30 && t < 35), 1'b1, 1'b0, 0);
        n_tests++;
        if (col_strobe !== m_strobe || col_addr !== 3'(m_addr) || locked !== m_locked) begin
          n_fail++;
          $display("FAIL glitch cyc=%0d strobe=%b exp %b addr=%0d exp %0d locked=%b exp %b",
                   cyc, col_strobe, m_strobe, col_addr, m_addr, locked, m_locked);
        end
      end
    end
    n_tests++;
    if (rev_period !== 24'd800 || locked !== 1'b1) begin
      n_fail++;
      $display("FAIL glitch_ignored rev=%0d locked=%b expected 800,1", rev_period, locked);
    end
  endtask

  task automatic test_offset_wrap();
    int addrs[$];
    for (int r = 0; r < 3; r++) begin
      addrs.delete();
      for (int t = 0; t < 800; t++) begin
        cycle(t < 5, 1'b1, 1'b0, 6);
        n_tests++;
        if (col_strobe !== m_strobe || col_addr !== 3'(m_addr)) begin
          n_fail++;
          $display("FAIL offset cyc=%0d strobe=%b exp %b addr=%0d exp %0d",
                   cyc, col_strobe, m_strobe, col_addr, m_addr);
        end
        if (col_strobe === 1'b1) addrs.push_back(int'(col_addr));
      end
    end
    n_tests++;
    if (addrs.size() != 8) begin
      n_fail++;
      $display("FAIL offset_strobe_count got %0d expected 8", addrs.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        n_tests++;
        if (addrs[i] != (6 + i) % 8) begin
          n_fail++;
          $display("FAIL offset_seq idx=%0d got %0d expected %0d", i, addrs[i], (6 + i) % 8);
        end
      end
    end
  endtask

  task automatic test_speed_change();
    int periods[6]  = '{800, 400, 400, 800, 1600, 800};
    int exp_cnt[6]  = '{8, 4, 8, 8, 8, 4};
    int strobes;
    for (int k = 0; k < 6; k++) begin
      strobes = 0;
      for (int t = 0; t < periods[k]; t++) begin
        cycle(t < 5, 1'b1, 1'b0, 0);
        n_tests++;
        if (col_strobe !== m_strobe || col_addr !== 3'(m_addr) || rev_period !== 24'(m_rev)) begin
          n_fail++;
          $display("FAIL speed cyc=%0d strobe=%b exp %b addr=%0d exp %0d rev=%0d exp %0d",
                   cyc, col_strobe, m_strobe, col_addr, m_addr, rev_period, m_rev);
        end
        if (col_strobe === 1'b1) strobes++;
        if (k == 4 && t == 1599) begin
          n_tests++;
          if (col_addr !== 3'd7) begin
            n_fail++;
            $display("FAIL speed_slow_hold addr=%0d expected 7", col_addr);
          end
        end
      end
      n_tests++;
      if (strobes != exp_cnt[k]) begin
        n_fail++;
        $display("FAIL speed_strobe_count seg=%0d got %0d expected %0d", k, strobes, exp_cnt[k]);
      end
    end
  endtask

  task automatic test_random();
    int p, g, o;
    bit e, gl;
    for (int r = 0; r < 25; r++) begin
      p  = int'($urandom_range(48, 1500));
      g  = int'($urandom_range(8, 50));
      gl = ($urandom_range(0, 3) == 0) && (p > g + 12);
      o  = int'($urandom_range(0, 7));
      e  = ($urandom_range(0, 3) != 0);
      for (int t = 0; t < p; t++) begin
        cycle((t < 5) || (gl && t >= g && t < g + 5), e, 1'b0, o);
        n_tests++;
        if (col_strobe !== m_strobe || col_addr !== 3'(m_addr) || locked !== m_locked ||
            blank !== m_blank || rev_period !== 24'(m_rev)) begin
          n_fail++;
          $display("FAIL random cyc=%0d strobe=%b exp %b addr=%0d exp %0d locked=%b exp %b blank=%b exp %b rev=%0d exp %0d",
                   cyc, col_strobe, m_strobe, col_addr, m_addr, locked, m_locked, blank, m_blank, rev_period, m_rev);
        end
      end
    end
  endtask

  task automatic test_stall();
    for (int r = 0; r < 2; r++) begin
      for (int t = 0; t < 800; t++) cycle(t < 5, 1'b1, 1'b0, 0);
    end
    n_tests++;
    if (locked !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_precondition locked=%b expected 1", locked);
    end
    for (int t = 0; t < 4200; t++) begin
      cycle(1'b0, 1'b1, 1'b0, 0);
      n_tests++;
      if (col_strobe !== m_strobe || locked !== m_locked || blank !== m_blank) begin
        n_fail++;
        $display("FAIL stall cyc=%0d strobe=%b exp %b locked=%b exp %b blank=%b exp %b",
                 cyc, col_strobe, m_strobe, locked, m_locked, blank, m_blank);
      end
    end
    n_tests++;
    if (locked !== 1'b0 || blank !== 1'b1 || col_strobe !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_final locked=%b blank=%b strobe=%b expected 0,1,0", locked, blank, col_strobe);
    end
  endtask

  task automatic test_reset_mid_run();
    for (int r = 0; r < 3; r++) begin
      for (int t = 0; t < 800; t++) cycle(t < 5, 1'b1, 1'b0, 3);
    end
    for (int t = 0; t < 300; t++) cycle(t < 5, 1'b1, 1'b0, 3);
    n_tests++;
    if (locked !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid_precondition locked=%b expected 1", locked);
    end
    cycle(1'b0, 1'b1, 1'b1, 3);
    n_tests++;
    if (col_addr !== 3'd0 || col_strobe !== 1'b0 || locked !== 1'b0 || blank !== 1'b1 || rev_period !== 24'd0) begin
      n_fail++;
      $display("FAIL reset_mid_values addr=%0d strobe=%b locked=%b blank=%b rev=%0d expected 0,0,0,1,0",
               col_addr, col_strobe, locked, blank, rev_period);
    end
    for (int t = 0; t < 200; t++) begin
      cycle((t < 5) || (t >= 40 && t < 45) || (t >= 64 && t < 69), 1'b1, 1'b0, 3);
      n_tests++;
      if (col_strobe !== m_strobe || col_addr !== 3'(m_addr) || locked !== m_locked || blank !== m_blank) begin
        n_fail++;
        $display("FAIL relock cyc=%0d strobe=%b exp %b addr=%0d exp %0d locked=%b exp %b blank=%b exp %b",
                 cyc, col_strobe, m_strobe, col_addr, m_addr, locked, m_locked, blank, m_blank);
      end
      if (t == 60) begin
        n_tests++;
        if (locked !== 1'b0) begin
          n_fail++;
          $display("FAIL relock_needs_two_rises locked=%b expected 0", locked);
        end
      end
      if (t == 100) begin
        n_tests++;
        if (locked !== 1'b1 || rev_period !== 24'd64) begin
          n_fail++;
          $display("FAIL relock_min_period locked=%b rev=%0d expected 1,64", locked, rev_period);
        end
      end
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    cyc     = 0;
    m_state = 0; m_last = 0; m_rev = 0; m_int = 1; m_off = 0; m_addr = 0;
    m_strobe = 0; m_locked = 0; m_blank = 1;
    h1 = 0; h2 = 0; h3 = 0;
    hall   = 1'b0;
    en     = 1'b0;
    rst    = 1'b1;
    offset = 3'd0;

    test_reset();
    test_steady();
    test_glitch();
    test_offset_wrap();
    test_speed_change();
    test_random();
    test_stall();
    test_reset_mid_run();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/column_scheduler.md
COLUMN_SCHEDULER -- requirements
Module: column_scheduler

Interface
REQ-001 Parameter NUM_COLS, 128: columns per revolution; power of two, at least 4.
REQ-002 Parameter PERIOD_W, 24: width of the revolution-period counter.
REQ-003 Parameter MIN_PERIOD, 4096: shortest accepted revolution in clk cycles; at least 2*NUM_COLS.
REQ-004 Parameter MAX_PERIOD, 2**PERIOD_W-1: stall timeout in clk cycles.
REQ-005 Port clk, input, 1: clock.
REQ-006 Port rst, input, 1: reset, synchronous, active-high.
REQ-007 Port hall, input, 1: asynchronous hall-sensor pin; a rising edge marks the index position.
REQ-008 Port en, input, 1: display enable from the mode selector.
REQ-009 Port offset, input, log2(NUM_COLS): column phase offset, sampled on accepted edges.
REQ-010 Port col_addr, output, log2(NUM_COLS): pattern-memory column address.
REQ-011 Port col_strobe, output, 1: one-cycle pulse, asserted when col_addr takes a new column.
REQ-012 Port blank, output, 1: LEDs off.
REQ-013 Port locked, output, 1: high in RUN.
REQ-014 Port rev_period, output, PERIOD_W: last accepted revolution period.

Function
REQ-015 hall SHALL pass through a two-flop synchronizer and a rising-edge detector; a pin rise sampled at clk edge k SHALL yield internal hall_rise at edge k+2.
REQ-016 per_cnt SHALL count clk cycles since the last accepted edge and saturate at MAX_PERIOD.
REQ-017 A hall_rise SHALL be accepted only if per_cnt >= MIN_PERIOD, or if state is IDLE; other rises SHALL be ignored as glitches.
REQ-018 On each accepted edge, per_cnt SHALL restart so the next measured value equals the exact cycle distance between accepted edges.
REQ-019 FSM states SHALL be IDLE, ACQUIRE and RUN.
REQ-020 IDLE -> ACQUIRE on any hall_rise.
REQ-021 ACQUIRE -> RUN on the next accepted edge; rev_period SHALL latch per_cnt on that edge.
REQ-022 ACQUIRE or RUN -> IDLE when per_cnt reaches MAX_PERIOD.
REQ-023 In RUN, every accepted edge SHALL latch rev_period.
REQ-024 col_interval SHALL equal the just-latched rev_period >> log2(NUM_COLS), truncated; a new interval SHALL take effect from the edge that measured it.
REQ-025 On entry to RUN and on each accepted edge in RUN, the scheduler SHALL:
  - clear col_cnt and the column timer;
  - latch offset;
  - pulse col_strobe in the following cycle.
REQ-026 Each time the column timer reaches col_interval-1, col_cnt SHALL increment and col_strobe SHALL pulse.
REQ-027 col_cnt SHALL saturate at NUM_COLS-1; no further strobes SHALL occur until the next accepted edge (slow-down case).
REQ-028 If an accepted edge arrives before col_cnt reaches NUM_COLS-1 (speed-up case), col_cnt SHALL realign to 0; edge realignment takes priority over the timer increment in the same cycle.
REQ-029 col_addr SHALL equal (col_cnt + latched offset) mod NUM_COLS, wrapping, and SHALL be registered.
REQ-030 blank SHALL be the registered value of NOT (RUN AND en).
REQ-031 col_strobe SHALL be 0 whenever the state is not RUN.
REQ-032 en SHALL gate only blank; measurement and scheduling SHALL continue while en is 0.

Reset
REQ-033 rst SHALL force, at the next clk edge:
  - state = IDLE;
  - per_cnt, col_cnt, column timer, rev_period, latched offset = 0;
  - col_addr = 0, col_strobe = 0, locked = 0, blank = 1;
  - synchronizer flops = 0.
REQ-034 rst asserted mid-RUN SHALL abort scheduling immediately; the first post-reset rise SHALL only enter ACQUIRE.

Structure
REQ-035 Shared package led_fan_pkg SHALL hold the NUM_COLS, COL_W, PERIOD_W, MIN_PERIOD and MAX_PERIOD defaults and the IDLE/ACQUIRE/RUN encoding.
REQ-036 Sub-module hall_sync_edge SHALL implement the synchronizer and rising-edge detector.

Verification
All scenarios use NUM_COLS=8, MIN_PERIOD=64, MAX_PERIOD=4096.
REQ-037 Steady rotation: hall rises every 800 cycles, offset=0 -> locked after the second rise; rev_period=800; strobes every 100 cycles; col_addr 0..7 per revolution; blank=0 with en=1.
REQ-038 Glitch: extra hall rise 30 cycles after an accepted edge -> ignored; rev_period stays 800; strobe timing unchanged.
REQ-039 Offset wrap: offset=6 -> col_addr sequence 6,7,0,1,2,3,4,5 after each edge.
REQ-040 Speed change:
  - period 800 -> 400: interval 50 from that edge, col_addr realigned to 0.
  - period 800 -> 1600: col_addr holds 7 from cycle 700 until the next edge, with no extra strobes.
REQ-041 Stall: hall stops -> 4096 cycles after the last accepted edge, state IDLE, locked=0, blank=1, col_strobe=0.
REQ-042 Reset mid-RUN: rst pulsed -> all REQ-033 values next cycle; relock requires two rises at least 64 cycles apart.
